// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//  Bundles every signal that crosses the data-memory port arbiter: the core
//  (EX/MEM) request side, the CNN accelerator load/store beat side, and the
//  single physical datamemory port.
//
//  Modports
//   slave  : the arbiter's view. Requests and mem_rdata come in; grants,
//            stalls, read data and the memory command go out.
//   master : the surrounding system's view (pipeline, accelerator engine and
//            datamemory together). It drives requests and mem_rdata and
//            observes everything the arbiter produces.
//
//  Signal groups
//   core_* : core_rd, core_wr, core_addr, core_wdata, core_funct3 (requests);
//            core_rdata, core_stall (responses)
//   acc_*  : acc_req, acc_we, acc_addr, acc_wdata, acc_last (requests);
//            acc_gnt, acc_rdata, acc_rvalid (responses)
//   mem_*  : mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3 (to memory);
//            mem_rdata (from memory, combinational read)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  // core (pipeline MEM stage) side
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [2:0]        core_funct3;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;

  // accelerator load/store engine side
  logic              acc_req;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_last;
  logic              acc_gnt;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_rvalid;

  // shared datamemory port
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_rd, core_wr, core_addr, core_wdata, core_funct3,
    output core_rdata, core_stall,
    input  acc_req, acc_we, acc_addr, acc_wdata, acc_last,
    output acc_gnt, acc_rdata, acc_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output core_rd, core_wr, core_addr, core_wdata, core_funct3,
    input  core_rdata, core_stall,
    output acc_req, acc_we, acc_addr, acc_wdata, acc_last,
    input  acc_gnt, acc_rdata, acc_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//  Shares the single data-memory port between the pipeline MEM stage (core)
//  and the CNN accelerator load/store engine (acc). The core normally wins;
//  the accelerator is served when the core is idle, or forcibly after it has
//  waited MAX_WAIT-1 cycles behind the core. Once the accelerator owns the
//  port it may keep it for at most BURST_MAX consecutive beats, which bounds
//  how long the core can be stalled.
//
//  Parameters
//   ADDR_W    data-memory byte address width
//   DATA_W    data width
//   MAX_WAIT  cycles acc may wait behind core before a forced grant (>=1)
//   BURST_MAX max acc beats per grant window (>=1)
//
//  Ports
//   clk    clock
//   reset  synchronous, active-high
//   bus    dmem_port_arbiter_if.slave: core request/response, acc beat
//          handshake (acc_req/acc_gnt, acc_rvalid one cycle after a read
//          beat), and the datamemory command port (mem_*).
//
//  core_stall is high when the core presents an access that is not granted;
//  the pipeline then holds its request stable, so no core state is kept here.
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  dmem_port_arbiter_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MAX_WAIT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LIMIT  = BEAT_W'(BURST_MAX - 1);
  localparam logic [2:0]        FUNCT3_WORD = 3'b010;

  typedef enum logic [0:0] {
    S_CORE,   // core owns the port by default, acc served when allowed
    S_ACC     // acc inside a grant window
  } state_t;

  state_t            state_reg,      state_next;
  logic [WAIT_W-1:0] wait_cnt_reg,   wait_cnt_next;
  logic [BEAT_W-1:0] beat_cnt_reg,   beat_cnt_next;
  logic              acc_rvalid_reg, acc_rvalid_next;
  logic [DATA_W-1:0] acc_rdata_reg,  acc_rdata_next;

  logic              core_act;
  logic              force_acc;
  logic              grant_core;
  logic              grant_acc;
  logic              acc_rd_beat;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign core_act  = bus.core_rd | bus.core_wr;
  // Only meaningful in S_CORE: the accelerator has waited long enough.
  assign force_acc = bus.acc_req & (wait_cnt_reg == WAIT_LIMIT);

  // -------------------------------------------------------------------------
  // State and counter registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_CORE;
      wait_cnt_reg   <= '0;
      beat_cnt_reg   <= '0;
      acc_rvalid_reg <= 1'b0;
      acc_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
      acc_rvalid_reg <= acc_rvalid_next;
      acc_rdata_reg  <= acc_rdata_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / grant logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    beat_cnt_next = beat_cnt_reg;
    grant_core    = 1'b0;
    grant_acc     = 1'b0;

    unique case (state_reg)
      S_CORE: begin
        if (bus.acc_req && (!core_act || force_acc)) begin
          // Opening beat of a window: it already counts as beat 1.
          grant_acc     = 1'b1;
          wait_cnt_next = '0;
          if (bus.acc_last || (BURST_MAX == 1)) begin
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = BEAT_W'(1);
            state_next    = S_ACC;
          end
        end else if (core_act) begin
          grant_core = 1'b1;
          // Counts only cycles where acc is actually kept waiting.
          wait_cnt_next = wait_cnt_reg + WAIT_W'(bus.acc_req);
        end
      end

      S_ACC: begin
        if (bus.acc_req) begin
          grant_acc = 1'b1;
          if (bus.acc_last || (beat_cnt_reg == BEAT_LIMIT)) begin
            beat_cnt_next = '0;
            state_next    = S_CORE;
          end else begin
            beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
          end
        end else begin
          // Burst abandoned without acc_last: hand the port straight back so
          // the core does not lose this cycle.
          grant_core    = core_act;
          beat_cnt_next = '0;
          state_next    = S_CORE;
        end
      end

      default: begin
        state_next    = S_CORE;
        wait_cnt_next = '0;
        beat_cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Accelerator read-data capture: mem_rdata is combinational, so the word
  // for a granted read beat is registered and presented the next cycle.
  // -------------------------------------------------------------------------
  assign acc_rd_beat = grant_acc & ~bus.acc_we;

  always_comb begin
    acc_rvalid_next = acc_rd_beat;
    acc_rdata_next  = acc_rdata_reg;
    if (acc_rd_beat) begin
      acc_rdata_next = bus.mem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Memory port mux. Grants are one-hot (or both zero), so an AND-OR mux per
  // bit yields the owner's fields and all-zero when the port is unused.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_addr_mux
      assign addr_mux[gi] = (grant_core & bus.core_addr[gi]) |
                            (grant_acc  & bus.acc_addr[gi]);
    end
    for (gi = 0; gi < DATA_W; gi++) begin : g_wdata_mux
      assign wdata_mux[gi] = (grant_core & bus.core_wdata[gi]) |
                             (grant_acc  & bus.acc_wdata[gi]);
    end
  endgenerate

  assign bus.mem_rd     = (grant_core & bus.core_rd) | (grant_acc & ~bus.acc_we);
  assign bus.mem_wr     = (grant_core & bus.core_wr) | (grant_acc &  bus.acc_we);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  // Accelerator beats are always full words.
  assign bus.mem_funct3 = grant_core ? bus.core_funct3 :
                          grant_acc  ? FUNCT3_WORD     : 3'b000;

  // -------------------------------------------------------------------------
  // Responses
  // -------------------------------------------------------------------------
  assign bus.core_rdata = bus.mem_rdata;
  assign bus.core_stall = core_act & ~grant_core;
  assign bus.acc_gnt    = grant_acc;
  assign bus.acc_rdata  = acc_rdata_reg;
  assign bus.acc_rvalid = acc_rvalid_reg;

endmodule
